// File: rtl/ucode_pkg.sv
// Encodings shared between the microcode sequencer and ucode_datapath:
// bus/address select codes, control-word bit positions, vector constants.
package ucode_pkg;

  localparam logic [3:0] SRC_Y     = 4'h0;
  localparam logic [3:0] SRC_X     = 4'h1;
  localparam logic [3:0] SRC_SP    = 4'h2;
  localparam logic [3:0] SRC_ALU   = 4'h3;
  localparam logic [3:0] SRC_A     = 4'h4;
  localparam logic [3:0] SRC_PCL   = 4'h5;
  localparam logic [3:0] SRC_PCH   = 4'h6;
  localparam logic [3:0] SRC_IDLB  = 4'h7;
  localparam logic [3:0] SRC_DBUFF = 4'h8;
  localparam logic [3:0] SRC_PSR   = 4'h9;
  localparam logic [3:0] SRC_ZERO  = 4'hA;

  localparam logic [2:0] AH_ONE  = 3'b010;
  localparam logic [2:0] AH_PCH  = 3'b101;
  localparam logic [2:0] AH_IDLA = 3'b110;
  localparam logic [2:0] AL_Y    = 3'b000;
  localparam logic [2:0] AL_X    = 3'b001;
  localparam logic [2:0] AL_SP   = 3'b010;
  localparam logic [2:0] AL_ALU  = 3'b011;
  localparam logic [2:0] AL_PCL  = 3'b101;
  localparam logic [2:0] AL_IDLB = 3'b110;

  localparam int LSE_ALU_COMPUTE     = 15;
  localparam int LSE_LOAD_Y          = 14;
  localparam int LSE_LOAD_X          = 13;
  localparam int LSE_LOAD_SP         = 12;
  localparam int LSE_LOAD_ALU        = 11;
  localparam int LSE_LOAD_A          = 10;
  localparam int LSE_LOAD_PCL        = 9;
  localparam int LSE_LOAD_PCH        = 8;
  localparam int LSE_LOAD_PSR        = 7;
  localparam int LSE_LOAD_BUS_BUFFER = 6;
  localparam int LSE_LOAD_DATA_LATCH = 5;
  localparam int LSE_LOAD_IREG       = 4;
  localparam int LSE_UPDATE_STATUS   = 3;
  localparam int LSE_MOV_ALU_TO_ACC  = 2;
  localparam int LSE_MOV_ACC_TO_ALU  = 1;
  localparam int LSE_MOV_LOW_TO_ALU  = 0;

  localparam int IDC_INC_PC    = 9;
  localparam int IDC_INC_SP    = 8;
  localparam int IDC_DEC_SP    = 7;
  localparam int IDC_INC_X     = 6;
  localparam int IDC_DEC_X     = 5;
  localparam int IDC_INC_Y     = 4;
  localparam int IDC_DEC_Y     = 3;
  localparam int IDC_INC_A     = 2;
  localparam int IDC_DEC_A     = 1;
  localparam int IDC_CLEAR_IDL = 0;

  localparam int VEC_START = 4;
  localparam int VEC_RESET = 3;
  localparam int VEC_NMI   = 2;
  localparam int VEC_IRQ   = 1;
  localparam int VEC_STACK = 0;

  localparam logic [15:0] VEC_BASE_RESET = 16'hFFFC;
  localparam logic [15:0] VEC_BASE_NMI   = 16'hFFFA;
  localparam logic [15:0] VEC_BASE_IRQ   = 16'hFFFE;

  typedef enum logic [2:0] {
    ST_IDLE, ST_STK0, ST_STK1, ST_STK2, ST_VECL, ST_VECH
  } vec_state_t;

  function automatic logic [15:0] vec_base(input logic [4:0] ops);
    if (ops[VEC_RESET]) return VEC_BASE_RESET;
    if (ops[VEC_NMI])   return VEC_BASE_NMI;
    return VEC_BASE_IRQ;
  endfunction

  function automatic logic [7:0] step8(input logic [7:0] v, input logic inc, input logic dec);
    if (inc && !dec) return v + 8'd1;
    if (dec && !inc) return v - 8'd1;
    return v;
  endfunction

endpackage

// File: rtl/ucode_vector_fsm.sv
// Reset/NMI/IRQ vector-fetch sequencer; the dummy stack reads exist only
// when UCODE_DP_STACK_INIT_EN is defined. All outputs are registered.
module ucode_vector_fsm
  import ucode_pkg::*;
(
  input  logic        i_fclk,
  input  logic        i_reset,
  input  logic [4:0]  i_vec_ops,
  output logic        o_busy,
  output logic        o_stk,
  output logic        o_vecl,
  output logic        o_vech,
  output logic        o_sp_fd,
  output logic [15:0] o_vec_addr
);

  // state | meaning
  // IDLE  | sequencer owns the datapath
  // STK0-2| dummy stack reads at {01,SP}, SP decrements
  // VECL  | read vector low byte into PCL
  // VECH  | read vector high byte into PCH, set I, clear D
  vec_state_t  r_state;
  logic        r_busy, r_stk, r_vecl, r_vech, r_sp_fd;
  logic [15:0] r_addr;

  always_ff @(posedge i_fclk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_stk   <= 1'b0;
      r_vecl  <= 1'b0;
      r_vech  <= 1'b0;
      r_sp_fd <= 1'b0;
      r_addr  <= 16'h0000;
    end else begin
      case (r_state)
        ST_IDLE: if (i_vec_ops[VEC_START]) begin
          r_busy <= 1'b1;
          r_addr <= vec_base(i_vec_ops);
`ifdef UCODE_DP_STACK_INIT_EN
          r_sp_fd <= 1'b0;
          if (i_vec_ops[VEC_STACK]) begin
            r_state <= ST_STK0;
            r_stk   <= 1'b1;
          end else begin
            r_state <= ST_VECL;
            r_vecl  <= 1'b1;
          end
`else
          // Without dummy reads the stack bit just presets SP during VECL
          r_sp_fd <= i_vec_ops[VEC_STACK];
          r_state <= ST_VECL;
          r_vecl  <= 1'b1;
`endif
        end
`ifdef UCODE_DP_STACK_INIT_EN
        ST_STK0: r_state <= ST_STK1;
        ST_STK1: r_state <= ST_STK2;
        ST_STK2: begin
          r_state <= ST_VECL;
          r_stk   <= 1'b0;
          r_vecl  <= 1'b1;
        end
`endif
        ST_VECL: begin
          r_state <= ST_VECH;
          r_vecl  <= 1'b0;
          r_vech  <= 1'b1;
          r_sp_fd <= 1'b0;
          r_addr  <= r_addr + 16'd1;
        end
        ST_VECH: begin
          r_state <= ST_IDLE;
          r_vech  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_stk   <= 1'b0;
          r_vecl  <= 1'b0;
          r_vech  <= 1'b0;
          r_sp_fd <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_stk      = r_stk;
  assign o_vecl     = r_vecl;
  assign o_vech     = r_vech;
  assign o_sp_fd    = r_sp_fd;
  assign o_vec_addr = r_addr;

endmodule

// File: rtl/ucode_datapath.sv
// 65C02 execution datapath driven by the microcode control word.
// UCODE_DP_STACK_INIT_EN adds dummy stack reads to the vector sequence.
module ucode_datapath
  import ucode_pkg::*;
#(
  parameter logic [7:0] RESET_SP  = 8'h00,
  parameter logic [7:0] RESET_PSR = 8'h34
) (
  input  logic        fclk,
  input  logic        reset,
  input  logic [3:0]  signal_set,
  input  logic [7:0]  data_bus_set,
  input  logic [5:0]  address_bus_set,
  input  logic [15:0] load_store_execute,
  input  logic [5:0]  alu_operations_regs,
  input  logic [9:0]  inc_dec_clr,
  input  logic [7:0]  status_flags,
  input  logic [4:0]  vector_operations,
  input  logic        adb_to_pc,
  input  logic [7:0]  data_in,
  input  logic [7:0]  alu_result,
  input  logic [7:0]  alu_flags,
  output logic [15:0] addr_out,
  output logic [7:0]  data_out,
  output logic        rwb,
  output logic        vpb_n,
  output logic        mlb_n,
  output logic        sync,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [5:0]  alu_op,
  output logic        alu_go,
  output logic [7:0]  ireg,
  output logic        busy
);

  logic [7:0]  r_a, r_x, r_y, r_sp, r_psr, r_dbuff, r_idl_a, r_idl_b, r_ireg, r_alu_a, r_alu_b;
  logic [15:0] r_pc;
  logic        r_hold;
  logic        w_busy, w_stk, w_vecl, w_vech, w_sp_fd, w_ctrl_any, w_force, w_adb;
  logic [15:0] w_vec_addr, w_lse, w_addr;
  logic [9:0]  w_idc;
  logic [3:0]  w_rd_src, w_wr_dst;
  logic [7:0]  w_bus, w_addr_h, w_addr_l;
  logic        w_ld_y, w_ld_x, w_ld_sp, w_ld_alu, w_ld_a, w_ld_pcl, w_ld_pch, w_ld_psr;

  ucode_vector_fsm u_vec (
    .i_fclk(fclk), .i_reset(reset), .i_vec_ops(vector_operations),
    .o_busy(w_busy), .o_stk(w_stk), .o_vecl(w_vecl), .o_vech(w_vech),
    .o_sp_fd(w_sp_fd), .o_vec_addr(w_vec_addr)
  );

  assign w_ctrl_any = |{signal_set, data_bus_set, address_bus_set, load_store_execute,
                        inc_dec_clr, status_flags, vector_operations, adb_to_pc};
  // Pins stay parked after reset until the sequencer issues its first word
  assign w_force  = reset | (r_hold & ~w_ctrl_any);
  assign w_rd_src = w_busy ? SRC_ZERO : data_bus_set[7:4];
  assign w_wr_dst = data_bus_set[3:0];
  assign w_lse    = w_busy ? 16'h0000 : load_store_execute;
  assign w_idc    = w_busy ? 10'h000 : inc_dec_clr;
  assign w_adb    = adb_to_pc & ~w_busy;

  assign w_ld_y   = w_lse[LSE_LOAD_Y]   && (w_wr_dst == SRC_Y);
  assign w_ld_x   = w_lse[LSE_LOAD_X]   && (w_wr_dst == SRC_X);
  assign w_ld_sp  = w_lse[LSE_LOAD_SP]  && (w_wr_dst == SRC_SP);
  assign w_ld_alu = w_lse[LSE_LOAD_ALU] && (w_wr_dst == SRC_ALU);
  assign w_ld_a   = w_lse[LSE_LOAD_A]   && (w_wr_dst == SRC_A);
  assign w_ld_pcl = w_lse[LSE_LOAD_PCL] && (w_wr_dst == SRC_PCL);
  assign w_ld_pch = w_lse[LSE_LOAD_PCH] && (w_wr_dst == SRC_PCH);
  assign w_ld_psr = w_lse[LSE_LOAD_PSR] && (w_wr_dst == SRC_PSR);

  always_comb begin
    w_bus = 8'h00;
    case (w_rd_src)
      SRC_Y:     w_bus = r_y;
      SRC_X:     w_bus = r_x;
      SRC_SP:    w_bus = r_sp;
      SRC_ALU:   w_bus = alu_result;
      SRC_A:     w_bus = r_a;
      SRC_PCL:   w_bus = r_pc[7:0];
      SRC_PCH:   w_bus = r_pc[15:8];
      SRC_IDLB:  w_bus = r_idl_b;
      SRC_DBUFF: w_bus = r_dbuff;
      SRC_PSR:   w_bus = r_psr;
      default:   w_bus = 8'h00;
    endcase
  end

  always_comb begin
    w_addr_h = 8'h00;
    w_addr_l = 8'h00;
    case (address_bus_set[5:3])
      AH_ONE:  w_addr_h = 8'h01;
      AH_PCH:  w_addr_h = r_pc[15:8];
      AH_IDLA: w_addr_h = r_idl_a;
      default: w_addr_h = 8'h00;
    endcase
    case (address_bus_set[2:0])
      AL_Y:    w_addr_l = r_y;
      AL_X:    w_addr_l = r_x;
      AL_SP:   w_addr_l = r_sp;
      AL_ALU:  w_addr_l = alu_result;
      AL_PCL:  w_addr_l = r_pc[7:0];
      AL_IDLB: w_addr_l = r_idl_b;
      default: w_addr_l = 8'h00;
    endcase
    if (w_force)     w_addr = 16'hFFFF;
    else if (w_busy) w_addr = w_stk ? {8'h01, r_sp} : w_vec_addr;
    else             w_addr = {w_addr_h, w_addr_l};
  end

  always_ff @(posedge fclk) begin
    if (reset) begin
      r_a <= 8'h00;  r_x <= 8'h00;  r_y <= 8'h00;
      r_sp <= RESET_SP;  r_psr <= RESET_PSR;  r_pc <= 16'h0000;
      r_dbuff <= 8'h00;  r_idl_a <= 8'h00;  r_idl_b <= 8'h00;
      r_ireg <= 8'h00;  r_alu_a <= 8'h00;  r_alu_b <= 8'h00;
      r_hold <= 1'b1;
    end else begin
      r_hold <= r_hold & ~w_ctrl_any;

      if (w_ld_a) r_a <= w_bus;
      else if (w_lse[LSE_MOV_ALU_TO_ACC]) r_a <= alu_result;
      else r_a <= step8(r_a, w_idc[IDC_INC_A], w_idc[IDC_DEC_A]);

      if (w_ld_x) r_x <= w_bus;
      else r_x <= step8(r_x, w_idc[IDC_INC_X], w_idc[IDC_DEC_X]);

      if (w_ld_y) r_y <= w_bus;
      else r_y <= step8(r_y, w_idc[IDC_INC_Y], w_idc[IDC_DEC_Y]);

      if (w_stk) r_sp <= r_sp - 8'd1;
      else if (w_vecl && w_sp_fd) r_sp <= 8'hFD;
      else if (w_ld_sp) r_sp <= w_bus;
      else r_sp <= step8(r_sp, w_idc[IDC_INC_SP], w_idc[IDC_DEC_SP]);

      if (w_lse[LSE_MOV_ACC_TO_ALU]) r_alu_a <= r_a;
      if (w_ld_alu) r_alu_b <= w_bus;
      else if (w_lse[LSE_MOV_LOW_TO_ALU]) r_alu_b <= w_addr[7:0];

      if (w_vecl) r_pc[7:0] <= data_in;
      else if (w_vech) r_pc[15:8] <= data_in;
      else if (w_adb) r_pc <= w_addr;
      else if (w_ld_pcl) r_pc[7:0] <= w_bus;
      else if (w_ld_pch) r_pc[15:8] <= w_bus;
      else if (w_idc[IDC_INC_PC]) r_pc <= r_pc + 16'd1;

      // Bits 5:4 of PSR are hard ones on the 65C02
      if (w_vech) r_psr <= (r_psr | 8'h04) & 8'hF7;
      else if (w_ld_psr) r_psr <= w_bus | 8'h30;
      else if (w_lse[LSE_UPDATE_STATUS])
        r_psr <= (r_psr & ~status_flags) | (alu_flags & status_flags);

      if (w_lse[LSE_LOAD_BUS_BUFFER]) r_dbuff <= data_in;
      if (w_lse[LSE_LOAD_IREG]) r_ireg <= data_in;
      if (w_lse[LSE_LOAD_DATA_LATCH]) begin
        r_idl_a <= data_in;
        r_idl_b <= r_idl_a;
      end else if (w_idc[IDC_CLEAR_IDL]) begin
        r_idl_a <= 8'h00;
        r_idl_b <= 8'h00;
      end
    end
  end

  assign addr_out = w_addr;
  assign data_out = w_bus;
  assign rwb      = (w_force | w_busy) ? 1'b1 : signal_set[0];
  assign mlb_n    = (w_force | w_busy) ? 1'b1 : ~signal_set[1];
  assign sync     = (w_force | w_busy) ? 1'b0 : signal_set[2];
  assign vpb_n    = w_force ? 1'b1 : ~((signal_set[3] & ~w_busy) | w_vecl | w_vech);
  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign alu_op   = alu_operations_regs;
  assign alu_go   = w_lse[LSE_ALU_COMPUTE];
  assign ireg     = r_ireg;
  assign busy     = w_busy;

endmodule

// File: tb/tb_ucode_datapath.sv
// Directed bench for ucode_datapath; follows UCODE_DP_STACK_INIT_EN for
// the expected vector-fetch sequence.
module tb_ucode_datapath;
  import ucode_pkg::*;

  logic        fclk = 1'b0;
  logic        reset;
  logic [3:0]  signal_set;
  logic [7:0]  data_bus_set;
  logic [5:0]  address_bus_set;
  logic [15:0] load_store_execute;
  logic [5:0]  alu_operations_regs;
  logic [9:0]  inc_dec_clr;
  logic [7:0]  status_flags;
  logic [4:0]  vector_operations;
  logic        adb_to_pc;
  logic [7:0]  data_in, alu_result, alu_flags;
  logic [15:0] addr_out;
  logic [7:0]  data_out, alu_a, alu_b, ireg;
  logic        rwb, vpb_n, mlb_n, sync, alu_go, busy;
  logic [5:0]  alu_op;

  int n_tests = 0;
  int n_fail  = 0;

  ucode_datapath dut (
    .fclk(fclk), .reset(reset), .signal_set(signal_set), .data_bus_set(data_bus_set),
    .address_bus_set(address_bus_set), .load_store_execute(load_store_execute),
    .alu_operations_regs(alu_operations_regs), .inc_dec_clr(inc_dec_clr),
    .status_flags(status_flags), .vector_operations(vector_operations),
    .adb_to_pc(adb_to_pc), .data_in(data_in), .alu_result(alu_result),
    .alu_flags(alu_flags), .addr_out(addr_out), .data_out(data_out), .rwb(rwb),
    .vpb_n(vpb_n), .mlb_n(mlb_n), .sync(sync), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_go(alu_go), .ireg(ireg), .busy(busy)
  );

  always #5 fclk = ~fclk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr_word();
    signal_set = '0; data_bus_set = '0; address_bus_set = '0; load_store_execute = '0;
    alu_operations_regs = '0; inc_dec_clr = '0; status_flags = '0;
    vector_operations = '0; adb_to_pc = 1'b0;
  endtask

  task automatic step();
    @(posedge fclk);
    #1;
  endtask

  task automatic rd_bus(input logic [3:0] src, input logic [7:0] exp, input string tag);
    clr_word();
    data_bus_set = {src, 4'hF};
    #1;
    chk(tag, {8'h00, data_out}, {8'h00, exp});
  endtask

  task automatic rd_pc(input logic [15:0] exp, input string tag);
    clr_word();
    address_bus_set = 6'b101101;
    #1;
    chk(tag, addr_out, exp);
  endtask

  task automatic set_reg(input logic [3:0] dst, input int ld_bit, input logic [7:0] v);
    clr_word();
    data_in = v;
    load_store_execute[LSE_LOAD_BUS_BUFFER] = 1'b1;
    step();
    clr_word();
    data_bus_set = {SRC_DBUFF, dst};
    load_store_execute[ld_bit] = 1'b1;
    step();
  endtask

  logic [15:0] ea[5];
  logic [7:0]  ed[5];
  logic        ev[5];
  int          nv;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
`ifdef UCODE_DP_STACK_INIT_EN
    nv = 5;
    ea[0] = 16'h0100; ea[1] = 16'h01FF; ea[2] = 16'h01FE; ea[3] = 16'hFFFC; ea[4] = 16'hFFFD;
    ed[0] = 8'h00; ed[1] = 8'h00; ed[2] = 8'h00; ed[3] = 8'h34; ed[4] = 8'h12;
    ev[0] = 1'b1; ev[1] = 1'b1; ev[2] = 1'b1; ev[3] = 1'b0; ev[4] = 1'b0;
`else
    nv = 2;
    ea[0] = 16'hFFFC; ea[1] = 16'hFFFD; ea[2] = 16'h0; ea[3] = 16'h0; ea[4] = 16'h0;
    ed[0] = 8'h34; ed[1] = 8'h12; ed[2] = 8'h0; ed[3] = 8'h0; ed[4] = 8'h0;
    ev[0] = 1'b0; ev[1] = 1'b0; ev[2] = 1'b1; ev[3] = 1'b1; ev[4] = 1'b1;
`endif
    reset = 1'b1; data_in = 8'h00; alu_result = 8'h00; alu_flags = 8'h00;
    clr_word();
    step(); step();
    chk("rst_addr", addr_out, 16'hFFFF);
    chk("rst_rwb", rwb, 1'b1);
    chk("rst_vpb_n", vpb_n, 1'b1);
    chk("rst_mlb_n", mlb_n, 1'b1);
    chk("rst_sync", sync, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    step();
    chk("post_rst_addr", addr_out, 16'hFFFF);
    chk("post_rst_rwb", rwb, 1'b1);
    rd_bus(SRC_A, 8'h00, "rst_a");
    rd_bus(SRC_SP, 8'h00, "rst_sp");
    rd_bus(SRC_PSR, 8'h34, "rst_psr");
    rd_pc(16'h0000, "rst_pc");

    // DBUFF load and A load from the old bus value in the same word
    clr_word();
    data_in = 8'h5A;
    data_bus_set = {SRC_DBUFF, SRC_A};
    load_store_execute[LSE_LOAD_BUS_BUFFER] = 1'b1;
    load_store_execute[LSE_LOAD_A] = 1'b1;
    step();
    rd_bus(SRC_DBUFF, 8'h5A, "dbuff_load");
    rd_bus(SRC_A, 8'h00, "a_old_bus");
    clr_word();
    data_bus_set = {SRC_DBUFF, SRC_A};
    load_store_execute[LSE_LOAD_BUS_BUFFER] = 1'b1;
    load_store_execute[LSE_LOAD_A] = 1'b1;
    step();
    rd_bus(SRC_A, 8'h5A, "a_second");

    // SP -> PCL with stack address select
    set_reg(SRC_SP, LSE_LOAD_SP, 8'hFD);
    clr_word();
    data_bus_set = {SRC_SP, SRC_PCL};
    load_store_execute[LSE_LOAD_PCL] = 1'b1;
    address_bus_set = 6'b010010;
    #1;
    chk("stack_addr", addr_out, 16'h01FD);
    step();
    rd_pc(16'h00FD, "pcl_from_sp");

    // PC wrap, inc+dec cancel, adb_to_pc priority
    set_reg(SRC_PCL, LSE_LOAD_PCL, 8'hFF);
    set_reg(SRC_PCH, LSE_LOAD_PCH, 8'hFF);
    rd_pc(16'hFFFF, "pc_ffff");
    set_reg(SRC_X, LSE_LOAD_X, 8'h80);
    clr_word();
    inc_dec_clr[IDC_INC_PC] = 1'b1;
    inc_dec_clr[IDC_INC_X] = 1'b1;
    inc_dec_clr[IDC_DEC_X] = 1'b1;
    step();
    rd_pc(16'h0000, "pc_wrap");
    rd_bus(SRC_X, 8'h80, "x_incdec");
    clr_word();
    inc_dec_clr[IDC_DEC_X] = 1'b1;
    step();
    rd_bus(SRC_X, 8'h7F, "x_dec");
    clr_word();
    adb_to_pc = 1'b1;
    inc_dec_clr[IDC_INC_PC] = 1'b1;
    address_bus_set = 6'b010010;
    step();
    rd_pc(16'h01FD, "adb_to_pc");

    // Status update and PSR load
    clr_word();
    status_flags = 8'h82;
    alu_flags = 8'hFF;
    load_store_execute[LSE_UPDATE_STATUS] = 1'b1;
    step();
    rd_bus(SRC_PSR, 8'hB6, "psr_update");
    clr_word();
    data_bus_set = {SRC_ZERO, SRC_PSR};
    load_store_execute[LSE_LOAD_PSR] = 1'b1;
    step();
    rd_bus(SRC_PSR, 8'h30, "psr_load");

    // Reset vector with stack bit
    set_reg(SRC_SP, LSE_LOAD_SP, 8'h00);
    set_reg(SRC_PSR, LSE_LOAD_PSR, 8'h08);
    clr_word();
    vector_operations = 5'b11001;
    #1;
    chk("vec_start_busy", busy, 1'b0);
    step();
    for (int i = 0; i < nv; i++) begin
      clr_word();
      if (i == 0) vector_operations = 5'b10100;
      data_in = ed[i];
      #1;
      chk("vec_busy", busy, 1'b1);
      chk("vec_addr", addr_out, ea[i]);
      chk("vec_vpb_n", vpb_n, ev[i]);
      chk("vec_rwb", rwb, 1'b1);
      step();
    end
    clr_word();
    #1;
    chk("vec_done", busy, 1'b0);
    step();
    chk("vec_dropped", busy, 1'b0);
    rd_pc(16'h1234, "vec_pc");
    rd_bus(SRC_SP, 8'hFD, "vec_sp");
    rd_bus(SRC_PSR, 8'h34, "vec_psr");

    // NMI beats IRQ; reset in VECL aborts the fetch
    clr_word();
    vector_operations = 5'b10110;
    step();
    clr_word();
    data_in = 8'h77;
    #1;
    chk("nmi_addr", addr_out, 16'hFFFA);
    chk("nmi_busy", busy, 1'b1);
    reset = 1'b1;
    step();
    chk("abort_busy", busy, 1'b0);
    reset = 1'b0;
    step();
    rd_pc(16'h0000, "abort_pc");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ucode_datapath.md
# ucode_datapath

Execution-side counterpart of the microcode sequencer. It consumes the sequencer's per-cycle control word (signal set, data-bus select, address-bus select, load/store/execute, ALU ops, inc/dec/clear, status mask, vector ops, adb-to-pc). From that word it updates the 65C02 register file, drives the internal data bus and the external address/data/control pins, and runs the reset/NMI/IRQ vector-fetch sequence autonomously. While that sequence runs, it stalls the sequencer through `busy`.

## Interface

**Parameters**
- `RESET_SP`, 8'h00, SP value at reset.
- `RESET_PSR`, 8'h34, PSR value at reset (X, B, I set).

**Ports**
- `fclk` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `signal_set` in 4: {vpb, sync, mlb, rwb} requests.
- `data_bus_set` in 8: {read_src[7:4], write_dst[3:0]}.
- `address_bus_set` in 6: {addh_sel[5:3], addl_sel[2:0]}.
- `load_store_execute` in 16: one-hot-able load/move strobes, bit15 alu_compute … bit0 mov_low_byte_to_alu.
- `alu_operations_regs` in 6: passed to the ALU.
- `inc_dec_clr` in 10: bit9 inc_pc … bit0 clear_idl.
- `status_flags` in 8: PSR update mask.
- `vector_operations` in 5: {start, reset, nmi, irq, stack}.
- `adb_to_pc` in 1: load PC from the address bus.
- `data_in` in 8: external data bus.
- `alu_result` in 8, `alu_flags` in 8: ALU outputs.
- `addr_out` out 16; `data_out` out 8; `rwb` out 1; `vpb_n` out 1; `mlb_n` out 1; `sync` out 1.
- `alu_a`, `alu_b` out 8: ALU operand registers.
- `alu_op` out 6; `alu_go` out 1; `ireg` out 8.
- `busy` out 1: sequencer must deassert clock_running while high.

## Operation

- **Read sources** (`read_src`): 0 Y, 1 X, 2 SP, 3 alu_result, 4 A, 5 PCL, 6 PCH, 7 IDL_B, 8 DBUFF, 9 PSR, A and 11–15 drive 8'h00.
- **Register writes:** register `write_dst` (same code map) takes the internal bus value only when its matching load bit is also set. The load bits are load_y, load_x, load_sp, load_alu→alu_b, load_a, load_pcl, load_pch, load_psr. load_psr forces bits 5:4 to 1.
- load_bus_buffer: DBUFF←data_in.
- load_data_latch: IDL_A←data_in, IDL_B←IDL_A.
- load_ireg: ireg←data_in.
- mov_alu_to_acc: A←alu_result. mov_acc_to_alu: alu_a←A. mov_low_byte_to_alu: alu_b←addr_out[7:0].
- update_status: PSR←(PSR & ~status_flags) | (alu_flags & status_flags).
- alu_go = alu_compute bit; alu_op = alu_operations_regs (combinational passthrough).
- **Address high select:** 010 8'h01, 101 PCH, 110 IDL_A, 111 and others 8'h00.
- **Address low select:** 000 Y, 001 X, 010 SP, 011 alu_result, 101 PCL, 110 IDL_B, 111 and others 8'h00.
- **Increment/decrement:** all 8-bit, wrap modulo 256; PC is 16-bit and wraps FFFF→0000.
  - inc and dec on the same register together: no change.
  - clear_idl zeroes IDL_A and IDL_B.
- **Per-register priority:** adb_to_pc > bus load / move > inc/dec/clear.
- **External pins:**
  - rwb = signal_set[0].
  - data_out = internal bus value.
  - mlb_n = ~signal_set[1]; sync = signal_set[2].
  - vpb_n = ~(signal_set[3] | vector fetch active).
- **Vector FSM** (states IDLE, STK0, STK1, STK2, VECL, VECH):
  - Starts from IDLE when `vector_operations[4]`=1. Priority for the vector select is reset > nmi > irq.
  - Vector base: reset FFFC, nmi FFFA, irq FFFE.
  - With the stack bit set, the FSM enters STK0; otherwise it goes straight to VECL.
  - STKn: addr = {01,SP}, rwb=1, SP decrements by 1 each state.
  - VECL: addr = base, PCL←data_in.
  - VECH: addr = base+1, PCH←data_in, I set, D cleared, then return to IDLE.
  - busy = (state≠IDLE). While busy, the control word is fully ignored and rwb is forced to 1.
  - A start request arriving while busy is dropped.

## Timing

- Control inputs are consumed combinationally in the cycle they are presented. All register updates occur at the following posedge fclk.
- addr_out, data_out and pins are combinational from registers and the current control word.
- data_in is sampled at the posedge ending the cycle.
- Vector start is presented in cycle N; the FSM's first state occupies cycle N+1.
- Reset vector with stack bit set: STK0–2 occupy N+1..N+3, VECL N+4, VECH N+5; busy is low again at N+6.
- Reset vector without stack bit: VECL N+1, VECH N+2.
- While `reset`=1, and for the cycle after it deasserts until the first control word:
  - A, X, Y, IDL, DBUFF, ireg, alu_a and alu_b = 0; PC = 0000.
  - SP = RESET_SP; PSR = RESET_PSR; FSM = IDLE; busy = 0.
  - addr_out = FFFF, rwb = 1, vpb_n = 1, mlb_n = 1, sync = 0.
- Reset asserted mid-FSM returns the FSM to IDLE in the next cycle. Partial PCL is discarded by the PC reset.

## Configuration

- `UCODE_DP_STACK_INIT_EN` defined: the STK0–2 dummy stack reads are built in, as described above.
- Not defined: STK states are absent. The stack bit instead loads SP←8'hFD in the VECL cycle. The reset vector takes 2 cycles.

## Structure

- Package `ucode_pkg` holds:
  - read/write source codes, address-select codes, and load_store_execute and inc_dec_clr bit indices;
  - vector bit positions and vector base constants;
  - the FSM state enum.
- These encodings are shared with the sequencer.
- One sub-module, `ucode_vector_fsm`: state register, addr override, busy and capture strobes. The datapath owns all registers.

## Test plan

- Reset then {read_dbuff, write_a} + load_bus_buffer|load_a with data_in=8'h5A → DBUFF=5A next cycle; A=00 because the bus carried the old DBUFF. Repeat the word → A=5A.
- {read_sp, write_pcl} + load_pcl with SP=FD; address select {stack,stack} → addr_out=01FD; PCL=FD next cycle.
- PC=FFFF with inc_pc → PC=0000. Same cycle with inc_x|dec_x → X unchanged. adb_to_pc with inc_pc → PC = addr_out.
- vector_operations=5'b11001, SP=00, data_in 34 then 12 on the vector reads:
  - with `UCODE_DP_STACK_INIT_EN` → addrs 0100, 01FF, 01FE, FFFC, FFFD;
  - end state SP=FD, PC=1234, vpb_n low on the FFFC/FFFD cycles, busy high for exactly 5 cycles.
- update_status with mask 8'h82, alu_flags=FF, PSR=34 → PSR=B6. Then load_psr from bus value 00 → PSR=30.
- nmi|irq requested together → vector FFFA. Second request during busy → ignored. reset asserted in VECL → FSM IDLE, PC=0000.
